// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one registered data-bus transaction
// per aligned load/store, stalls the pipeline until the bus acknowledges,
// formats load data and passes non-memory results straight through.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access in flight; decode the op presented by EX/MEM
// S_WAIT | bus request outstanding; hold everything until dbus_ack
// S_DONE | read data captured; present write-back, release the stall
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        misalign_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        is_load, is_store, is_mem, sz_byte, sz_half, sz_word, sign_ext;
  logic        misaligned, start, misalign_d;
  logic [3:0]  sel_d;
  logic [31:0] store_d, load_fmt, rdata_q;
  logic [1:0]  off_q;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  assign hi_o    = hi_i;
  assign lo_o    = lo_i;
  assign whilo_o = whilo_i;

  // Decode the op class, access size, lane select and replicated store data.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sign_ext = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1;  sz_byte = 1'b1; sign_ext = 1'b1; end
      EXE_LBU_OP: begin is_load = 1'b1;  sz_byte = 1'b1; end
      EXE_LH_OP:  begin is_load = 1'b1;  sz_half = 1'b1; sign_ext = 1'b1; end
      EXE_LHU_OP: begin is_load = 1'b1;  sz_half = 1'b1; end
      EXE_LW_OP:  is_load = 1'b1;
      EXE_SB_OP:  begin is_store = 1'b1; sz_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; sz_half = 1'b1; end
      EXE_SW_OP:  is_store = 1'b1;
      default:    ;
    endcase
    is_mem     = is_load | is_store;
    sz_word    = is_mem & ~sz_byte & ~sz_half;
    misaligned = (sz_half & mem_addr_i[0]) | (sz_word & (|mem_addr_i[1:0]));
    if (sz_byte) begin
      case (mem_addr_i[1:0])
        2'd0:    sel_d = 4'b1000;
        2'd1:    sel_d = 4'b0100;
        2'd2:    sel_d = 4'b0010;
        default: sel_d = 4'b0001;
      endcase
    end else if (sz_half) begin
      sel_d = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end else begin
      sel_d = 4'b1111;
    end
    if (is_load)      store_d = 32'h0;
    else if (sz_byte) store_d = {4{reg2_i[7:0]}};
    else if (sz_half) store_d = {2{reg2_i[15:0]}};
    else              store_d = reg2_i;
    // Reset masks the memory path so the stage behaves as a pass-through.
    start      = rst & (state_q == S_IDLE) & is_mem & ~misaligned;
    misalign_d = rst & (state_q == S_IDLE) & is_mem & misaligned;
  end

  // Pick the addressed big-endian lane from the captured word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = rdata_q[31:24];
      2'd1:    lane_b = rdata_q[23:16];
      2'd2:    lane_b = rdata_q[15:8];
      default: lane_b = rdata_q[7:0];
    endcase
    lane_h = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (sz_byte)      load_fmt = {{24{sign_ext & lane_b[7]}}, lane_b};
    else if (sz_half) load_fmt = {{16{sign_ext & lane_h[15]}}, lane_h};
    else              load_fmt = rdata_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state, stall request and write-back outputs.
  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    wd_o     = wd_i;
    wreg_o   = wreg_i;
    wdata_o  = wdata_i;
    case (state_q)
      S_IDLE: if (start) begin
        stallreq = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        stallreq = 1'b1;
        if (dbus_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (is_load) wdata_o = load_fmt;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst && (is_store || misalign_d)) wreg_o = 1'b0;
  end

  // Registered bus outputs, captured read data and the misalign pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_sel   <= 4'h0;
      dbus_wdata <= 32'h0;
      rdata_q    <= 32'h0;
      off_q      <= 2'd0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= misalign_d;
      if (start) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store;
        dbus_addr  <= {mem_addr_i[31:2], 2'b00};
        dbus_sel   <= sel_d;
        dbus_wdata <= store_d;
        off_q      <= mem_addr_i[1:0];
      end else if (state_q == S_WAIT && dbus_ack) begin
        dbus_req <= 1'b0;
        dbus_we  <= 1'b0;
        rdata_q  <= dbus_rdata;
      end
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: none; all widths come from the shared defines (RegBus = 32, RegAddrBus = 5, AluOpBus = 8).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (rst = 0 resets immediately, independent of clk).
REQ-004 wd_i, wreg_i, wdata_i  in  5/1/32  destination register, write enable, EX result (from EX/MEM latch).
REQ-005 hi_i, lo_i, whilo_i  in  32/32/1  HI/LO values and HI/LO write enable.
REQ-006 aluop_i, mem_addr_i, reg2_i  in  8/32/32  operation code, effective address, store data source.
REQ-007 wd_o, wreg_o, wdata_o  out  5/1/32  to MEM/WB latch.
REQ-008 hi_o, lo_o, whilo_o  out  32/32/1  to MEM/WB latch; always equal to hi_i, lo_i, whilo_i.
REQ-009 stallreq  out  1  combinational pipeline stall request to the stall controller.
REQ-010 dbus_req, dbus_we  out  1/1  data-bus request and write strobe, both registered.
REQ-011 dbus_addr, dbus_sel, dbus_wdata  out  32/4/32  word address with [1:0] = 0, byte lanes, store data; all registered.
REQ-012 dbus_ack, dbus_rdata  in  1/32  one-cycle acknowledge and read data (valid when ack = 1).
REQ-013 misalign_o  out  1  one-cycle pulse on a misaligned access.

Function
REQ-014 Memory operations: LB, LBU, LH, LHU, LW, SB, SH, SW (EXE_*_OP codes); every other aluop_i is a non-memory op.
REQ-015 Non-memory op: outputs pass wd_i/wreg_i/wdata_i through combinationally; stallreq = 0; no bus activity.
REQ-016 FSM states: IDLE, WAIT, DONE.
REQ-017 IDLE, valid aligned memory op: stallreq = 1; next edge -> WAIT with dbus_req = 1, dbus_we = 1 for stores, address/sel/wdata loaded.
REQ-018 WAIT: stallreq = 1; outputs held stable; dbus_ack = 0 -> remain in WAIT.
REQ-019 WAIT, dbus_ack = 1 -> on the same edge: capture dbus_rdata, set dbus_req = 0 and dbus_we = 0, go to DONE.
REQ-020 DONE: stallreq = 0; wdata_o = formatted load result (loads) or wdata_i (stores); next edge -> IDLE unconditionally.
REQ-021 IDLE does not restart an access in the first cycle after DONE, because the upstream latch has advanced.
REQ-022 Minimum memory-op occupancy: 3 cycles (IDLE, WAIT with ack, DONE); each extra ack-wait cycle adds 1.
REQ-023 Byte lanes are big-endian by address[1:0].
REQ-024 Byte access: addr 0..3 -> sel 1000, 0100, 0010, 0001.
REQ-025 Halfword access: addr 0 -> sel 1100; addr 2 -> sel 0011.
REQ-026 Word access: sel 1111.
REQ-027 Store data replication: SB = {4{reg2_i[7:0]}}; SH = {2{reg2_i[15:0]}}; SW = reg2_i.
REQ-028 Load formatting: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW takes the full word.
REQ-029 Loads: wreg_o = wreg_i; stores: wreg_o = 0.
REQ-030 Misaligned access (halfword with addr[0] = 1, or word with addr[1:0] != 0): no bus request; misalign_o = 1 for one cycle; wreg_o = 0; stallreq = 0; FSM stays IDLE.
REQ-031 dbus_ack while in IDLE or DONE is ignored.

Reset
REQ-032 rst = 0 forces asynchronously: state IDLE, dbus_req = 0, dbus_we = 0, dbus_addr = 0, dbus_sel = 0, dbus_wdata = 0, captured data = 0, misalign_o = 0.
REQ-033 During reset, combinational outputs follow the inputs per REQ-015, and stallreq = 0.
REQ-034 Reset asserted in WAIT abandons the access; an ack arriving after reset release is ignored.

Verification
REQ-035 LW, addr 0x100, ack on 2nd WAIT cycle, rdata 0x89ABCDEF -> stallreq high 3 cycles; wdata_o = 0x89ABCDEF in DONE; dbus_sel = 1111.
REQ-036 LB addr 0x101, rdata 0x1280FF00 -> sel 0100, wdata_o = 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-037 SH addr 0x202, reg2_i = 0x0000BEEF -> dbus_we = 1, sel 0011, dbus_wdata = 0xBEEFBEEF, wreg_o = 0 in DONE.
REQ-038 LW addr 0x103 -> misalign_o pulse, dbus_req stays 0, stallreq = 0, wreg_o = 0.
REQ-039 LW issued, rst pulled low in WAIT, ack arrives after release -> dbus_req = 0 immediately, state IDLE, no write-back.
REQ-040 Back-to-back SW then LH (addr 0x0, rdata 0x7FFF0000) -> two separate IDLE-WAIT-DONE sequences, second result 0x00007FFF.
